// File: rtl/sub_arbiter.sv
// sub_arbiter: two-requester arbiter in front of a shared N-bit add/subtract unit.
//
// One operation is in flight at a time. In IDLE a single requester is granted
// (the only valid one, or the one named by prio when both are valid), its
// operands are captured on the handshake edge, the result is computed and
// registered in EXEC, and it is presented in RESP until the consumer takes it.
//
// state | meaning
// IDLE  | no operation in flight, grant offered to a requester
// EXEC  | captured operands being computed, result registered on exit
// RESP  | result held on rsp_* until rsp_ready
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   req0_valid/ready/a/b/op            requester 0 (op: 0 = a-b, 1 = a+b)
//   req1_valid/ready/a/b/op            requester 1
//   rsp_valid, rsp_ready               result handshake
//   rsp_id, rsp_sum, rsp_c_out, rsp_ovf  result owner, value, carry, signed overflow
//   busy                               high whenever not in IDLE
module sub_arbiter #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   input  logic         req0_op,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   input  logic         req1_op,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [N-1:0] rsp_sum,
   output logic         rsp_c_out,
   output logic         rsp_ovf,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic         prio_q, prio_d;
   logic         grant, grant_vld;
   logic         accept;
   logic         load_op, load_rsp;

   logic [N-1:0] a_q, b_q;
   logic         op_q, id_q;

   logic [N-1:0] b_eff;
   logic [N:0]   full_sum;
   logic         ovf_c;

   // Grant selection; when nobody is valid grant_vld is low and grant is unused.
   always_comb begin
      grant_vld = req0_valid | req1_valid;
      grant     = (req0_valid & req1_valid) ? prio_q : req1_valid;
   end

   assign req0_ready = (state_q == IDLE) & grant_vld & ~grant;
   assign req1_ready = (state_q == IDLE) & grant_vld &  grant;
   assign accept     = (req0_ready & req0_valid) | (req1_ready & req1_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         prio_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      prio_d   = prio_q;
      load_op  = 1'b0;
      load_rsp = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               load_op = 1'b1;
               prio_d  = ~grant;
               state_d = EXEC;
            end
         end
         EXEC: begin
            load_rsp = 1'b1;
            state_d  = RESP;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand capture: the in-flight op is isolated from later req input changes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q  <= '0;
         b_q  <= '0;
         op_q <= 1'b0;
         id_q <= 1'b0;
      end else if (load_op) begin
         a_q  <= grant ? req1_a  : req0_a;
         b_q  <= grant ? req1_b  : req0_b;
         op_q <= grant ? req1_op : req0_op;
         id_q <= grant;
      end
   end

   // Subtract is a + ~b + 1: invert b and use ~op as the carry in.
   always_comb begin
      b_eff    = op_q ? b_q : ~b_q;
      full_sum = {1'b0, a_q} + {1'b0, b_eff} + {{N{1'b0}}, ~op_q};
      ovf_c    = (a_q[N-1] == b_eff[N-1]) & (full_sum[N-1] != a_q[N-1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_sum   <= '0;
         rsp_c_out <= 1'b0;
         rsp_ovf   <= 1'b0;
         rsp_id    <= 1'b0;
      end else if (load_rsp) begin
         rsp_sum   <= full_sum[N-1:0];
         rsp_c_out <= full_sum[N];
         rsp_ovf   <= ovf_c;
         rsp_id    <= id_q;
      end
   end

   assign rsp_valid = (state_q == RESP);
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sub_arbiter.sv
module tb_sub_arbiter;

   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req0_valid = 1'b0, req0_op = 1'b0;
   logic [N-1:0] req0_a = '0, req0_b = '0;
   logic         req1_valid = 1'b0, req1_op = 1'b0;
   logic [N-1:0] req1_a = '0, req1_b = '0;
   logic         req0_ready, req1_ready;
   logic         rsp_valid, rsp_id, rsp_c_out, rsp_ovf, busy;
   logic         rsp_ready = 1'b0;
   logic [N-1:0] rsp_sum;

   int n_cmp = 0;
   int n_err = 0;

   sub_arbiter #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_sum(rsp_sum), .rsp_c_out(rsp_c_out), .rsp_ovf(rsp_ovf),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference arithmetic from the numeric meaning of the operation.
   task automatic ref_calc(input logic [31:0] a, input logic [31:0] b, input logic op,
                           output logic [31:0] sum, output logic c, output logic ovf);
      longint unsigned full;
      longint sa, sb, sr;
      full = op ? (longint'(a) + longint'(b)) : (longint'(a) + (64'h1_0000_0000 - longint'(b)));
      sum  = full[31:0];
      c    = full[32];
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      sr   = op ? sa + sb : sa - sb;
      ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic        id;
      logic [31:0] a, b;
      logic        op;
      logic [31:0] sum;
      logic        c, ovf;
   } vec_t;

   vec_t vecs[8];

   // Single-requester transaction from IDLE, checking timing and result.
   task automatic run_vec(input vec_t v, input int idx);
      string s;
      s = $sformatf("v%0d", idx);
      if (v.id) begin
         req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_op = v.op;
      end else begin
         req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_op = v.op;
      end
      rsp_ready = 1'b0;
      #1;
      chk({s, "_rdy0"}, req0_ready, !v.id);
      chk({s, "_rdy1"}, req1_ready, v.id);
      @(posedge clk);
      #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
      req0_op = ~req0_op; req1_op = ~req1_op;
      @(negedge clk);
      chk({s, "_exec_valid"}, rsp_valid, 0);
      chk({s, "_exec_busy"}, busy, 1);
      @(negedge clk);
      chk({s, "_rsp_valid"}, rsp_valid, 1);
      chk({s, "_id"}, rsp_id, v.id);
      chk({s, "_sum"}, rsp_sum, v.sum);
      chk({s, "_c"}, rsp_c_out, v.c);
      chk({s, "_ovf"}, rsp_ovf, v.ovf);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk({s, "_idle_busy"}, busy, 0);
      chk({s, "_idle_valid"}, rsp_valid, 0);
      rsp_ready = 1'b0;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: pick = 32'h0;
         1: pick = 32'h1;
         2: pick = 32'h7FFF_FFFF;
         3: pick = 32'h8000_0000;
         4: pick = 32'hFFFF_FFFF;
         default: pick = $urandom;
      endcase
   endfunction

   initial begin
      int nacc, nrsp, both_hi;
      logic order[4];
      logic rids[4];
      logic [31:0] held_sum;

      vecs[0] = '{1'b0, 32'd5, 32'd3, 1'b0, 32'd2, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 32'd3, 32'd5, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 32'h7FFF_FFFF, 32'h1, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
      vecs[5] = '{1'b1, 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
      vecs[6] = '{1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0, 1'b1, 1'b1};

      // Reset state
      do_reset();
      #1;
      chk("rst_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sum", rsp_sum, 0);
      chk("rst_id", rsp_id, 0);
      chk("rst_c", rsp_c_out, 0);
      chk("rst_ovf", rsp_ovf, 0);
      @(negedge clk);

      foreach (vecs[i]) run_vec(vecs[i], i);

      // Both requesters held valid: alternating grants, never both ready.
      do_reset();
      req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
      req0_a = 32'd100; req0_b = 32'd1; req0_op = 1'b0;
      req1_a = 32'd200; req1_b = 32'd2; req1_op = 1'b1;
      nacc = 0; nrsp = 0; both_hi = 0;
      for (int cyc = 0; cyc < 40 && (nacc < 4 || nrsp < 4); cyc++) begin
         if (nacc == 4) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
         end
         #1;
         if (req0_ready && req1_ready) both_hi++;
         if ((req0_ready || req1_ready) && nacc < 4) begin
            order[nacc] = req1_ready;
            nacc++;
         end
         if (rsp_valid && nrsp < 4) begin
            rids[nrsp] = rsp_id;
            nrsp++;
         end
         @(negedge clk);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("rr_accepts", nacc, 4);
      chk("rr_responses", nrsp, 4);
      chk("rr_both_ready", both_hi, 0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rr_grant%0d", i), order[i], i % 2);
         chk($sformatf("rr_rspid%0d", i), rids[i], i % 2);
      end
      rsp_ready = 1'b0;
      @(negedge clk);

      // Backpressure: response held, no new grant while in RESP.
      req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd4; req0_op = 1'b1;
      @(posedge clk);
      #1;
      req0_valid = 1'b0; req0_a = 32'd999;
      req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd7; req1_op = 1'b0;
      @(negedge clk);
      chk("bp_exec_rdy1", req1_ready, 0);
      @(negedge clk);
      held_sum = rsp_sum;
      chk("bp_sum", held_sum, 32'd14);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_valid%0d", i), rsp_valid, 1);
         chk($sformatf("bp_busy%0d", i), busy, 1);
         chk($sformatf("bp_rdy1_%0d", i), req1_ready, 0);
         chk($sformatf("bp_hold%0d", i), rsp_sum, 32'd14);
         chk($sformatf("bp_id%0d", i), rsp_id, 0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_last_valid", rsp_valid, 1);
      @(negedge clk);
      chk("bp_rel_busy", busy, 0);
      chk("bp_rel_valid", rsp_valid, 0);
      chk("bp_rel_rdy1", req1_ready, 1);
      req1_valid = 1'b0; rsp_ready = 1'b0;
      @(negedge clk);

      // Reset during EXEC; prio is 1 here so the pre-reset grant goes to req1.
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("rx_pre_rdy1", req1_ready, 1);
      @(posedge clk);
      #2;
      chk("rx_in_exec", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rx_valid", rsp_valid, 0);
      chk("rx_busy", busy, 0);
      chk("rx_sum", rsp_sum, 0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("rx_norsp%0d", i), rsp_valid, 0);
         @(negedge clk);
      end
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("rx_rdy0", req0_ready, 1);
      chk("rx_rdy1", req1_ready, 0);
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Random stimulus against a transaction-level model.
      do_reset();
      begin
         int          m_stage;   // 0 waiting for a grant, 1 computing, 2 presenting
         logic        m_prio, m_id, m_op, m_rid, m_c, m_ovf, e_r0, e_r1;
         logic [31:0] m_a, m_b, m_sum;
         m_stage = 0; m_prio = 0; m_id = 0; m_op = 0; m_a = 0; m_b = 0;
         m_rid = 0; m_sum = 0; m_c = 0; m_ovf = 0;
         for (int cyc = 0; cyc < 3000; cyc++) begin
            req0_valid = ($urandom_range(0, 9) < 6);
            req1_valid = ($urandom_range(0, 9) < 6);
            req0_a = pick(); req0_b = pick(); req0_op = $urandom_range(0, 1);
            req1_a = pick(); req1_b = pick(); req1_op = $urandom_range(0, 1);
            rsp_ready = $urandom_range(0, 1);
            #1;
            e_r0 = (m_stage == 0) && req0_valid && (!req1_valid || m_prio == 1'b0);
            e_r1 = (m_stage == 0) && req1_valid && (!req0_valid || m_prio == 1'b1);
            chk("rnd_rdy0", req0_ready, e_r0);
            chk("rnd_rdy1", req1_ready, e_r1);
            chk("rnd_valid", rsp_valid, m_stage == 2);
            chk("rnd_busy", busy, m_stage != 0);
            chk("rnd_sum", rsp_sum, m_sum);
            chk("rnd_id", rsp_id, m_rid);
            chk("rnd_c", rsp_c_out, m_c);
            chk("rnd_ovf", rsp_ovf, m_ovf);
            if (m_stage == 0) begin
               if (e_r0 || e_r1) begin
                  m_id = e_r1;
                  m_a  = e_r1 ? req1_a : req0_a;
                  m_b  = e_r1 ? req1_b : req0_b;
                  m_op = e_r1 ? req1_op : req0_op;
                  m_prio = !m_id;
                  m_stage = 1;
               end
            end else if (m_stage == 1) begin
               ref_calc(m_a, m_b, m_op, m_sum, m_c, m_ovf);
               m_rid = m_id;
               m_stage = 2;
            end else if (rsp_ready) begin
               m_stage = 0;
            end
            @(negedge clk);
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sub_arbiter.md
SUB_ARBITER -- requirements
Module: sub_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req0_valid, input, 1 bit: requester 0 has an operation pending.
REQ-005 The block SHALL have port req0_ready, output, 1 bit: requester 0 operation accepted this cycle.
REQ-006 The block SHALL have port req0_a, input, N bits: requester 0 operand a.
REQ-007 The block SHALL have port req0_b, input, N bits: requester 0 operand b.
REQ-008 The block SHALL have port req0_op, input, 1 bit: requester 0 operation select, 0 = a-b, 1 = a+b.
REQ-009 The block SHALL have ports req1_valid, req1_ready, req1_a, req1_b and req1_op, with the same directions, widths and meanings as the requester 0 ports, for requester 1.
REQ-010 The block SHALL have port rsp_valid, output, 1 bit: result available.
REQ-011 The block SHALL have port rsp_ready, input, 1 bit: consumer takes the result.
REQ-012 The block SHALL have port rsp_id, output, 1 bit: index of the requester that owns the result.
REQ-013 The block SHALL have port rsp_sum, output, N bits: result.
REQ-014 The block SHALL have port rsp_c_out, output, 1 bit: carry out; for subtract, 1 = no borrow.
REQ-015 The block SHALL have port rsp_ovf, output, 1 bit: signed two's-complement overflow.
REQ-016 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 The block SHALL implement three states (IDLE, EXEC, RESP) and one priority pointer prio (0 = req0 preferred).
REQ-018 In IDLE, grant SHALL go to the only valid requester; if both are valid, grant SHALL go to requester prio.
REQ-019 reqX_ready SHALL be combinational: state==IDLE AND grant==X; it SHALL never be high outside IDLE or for both requesters at once.
REQ-020 On a handshake edge (valid and ready), the block SHALL capture a, b, op and id into internal registers, set prio to the other requester, and move to EXEC.
REQ-021 In EXEC, the block SHALL compute the result from the captured operands, register rsp_sum, rsp_c_out, rsp_ovf and rsp_id, and move to RESP on the next edge.
REQ-022 Subtract SHALL be computed as the N-bit sum a + ~b + 1, with carry out of bit N-1 as rsp_c_out.
REQ-023 Add SHALL be computed as a + b, with carry out of bit N-1 as rsp_c_out.
REQ-024 rsp_ovf SHALL be set when the effective operands (a and b or ~b) share a sign bit that differs from the sign bit of rsp_sum.
REQ-025 rsp_valid SHALL equal state==RESP.
REQ-026 rsp_* outputs SHALL stay stable while rsp_valid is high and rsp_ready is low.
REQ-027 When rsp_valid and rsp_ready are both high, the block SHALL return to IDLE on that edge.
REQ-028 Latency SHALL be: handshake at edge k, rsp_valid high after edge k+1; minimum spacing between accepts is 3 cycles.
REQ-029 A requester that deasserts valid before being granted SHALL lose no state and SHALL not affect prio.
REQ-030 Operand changes on req inputs after the handshake SHALL not affect the in-flight result.

Reset
REQ-031 rst_n low SHALL immediately, without waiting for clk, force state=IDLE, prio=0, rsp_valid=0, rsp_sum=0, rsp_c_out=0, rsp_ovf=0, rsp_id=0 and busy=0.
REQ-032 Reset during EXEC or RESP SHALL discard the in-flight operation, with no response produced after rst_n rises.
REQ-033 The first grant after reset with both requesters valid SHALL go to requester 0.

Verification
REQ-034 Bench SHALL cover, N=32: req0 sub a=5, b=3 -> rsp_sum=2, c_out=1, ovf=0, id=0, rsp_valid two edges after accept.
REQ-035 Bench SHALL cover: req1 sub a=3, b=5 -> rsp_sum=0xFFFFFFFE, c_out=0, ovf=0, id=1.
REQ-036 Bench SHALL cover: sub a=0x7FFFFFFF, b=0xFFFFFFFF -> rsp_sum=0x80000000, ovf=1; add a=b=0xFFFFFFFF -> 0xFFFFFFFE, c_out=1.
REQ-037 Bench SHALL cover: both requesters held valid for 4 ops -> grant order 0,1,0,1; the two ready signals are never high together.
REQ-038 Bench SHALL cover: rsp_ready held low 5 cycles -> rsp_* stable, no new grant, busy=1; release -> IDLE next edge.
REQ-039 Bench SHALL cover: rst_n pulsed low during EXEC -> rsp_valid=0 and busy=0 at once, no response afterward, next grant goes to req0.
